mul_arbiter: RTL and testbench
==============================

MUL_ARBITER -- requirements
Module: mul_arbiter

Interface
REQ-001 The module SHALL have parameter LEN, default 4, giving the mantissa operand width in bits.
REQ-002 The module SHALL have parameter NREQ, default 4, giving the number of requesters (2..8).
REQ-003 The module SHALL have parameter IDW, default 2, giving the requester-id width; it equals ceil(log2(NREQ)).
REQ-004 Ports SHALL be, one per line (name, direction, width, meaning):
 clk  in  1  single clock, rising edge
 rst  in  1  synchronous, active-high reset
 s_axis_tvalid  in  NREQ  per-requester operand valid
 s_axis_tready  out  NREQ  per-requester accept; at most one bit high per cycle
 s_axis_tdata_a  in  NREQ*LEN  operand A of requester i at bits [i*LEN +: LEN]
 s_axis_tdata_b  in  NREQ*LEN  operand B of requester i at bits [i*LEN +: LEN]
 m_axis_tvalid  out  1  product valid
 m_axis_tready  in  1  downstream accept
 m_axis_tdata  out  2*LEN  unsigned product A*B
 m_axis_tid  out  IDW  index of the requester that owns the product
 busy  out  1  high while either pipeline stage holds data

Function
REQ-005 A transfer on requester i SHALL occur in a cycle where s_axis_tvalid[i] and s_axis_tready[i] are both high; an output transfer SHALL occur when m_axis_tvalid and m_axis_tready are both high.
REQ-006 The block SHALL time-share one LEN x LEN unsigned multiplier across a two-stage pipeline: S1 holds registered operands plus id, and S2 holds the registered product plus id.
REQ-007 S2 SHALL load from S1 when S1 is valid and S2 is empty or drains in the same cycle (m_axis_tready high).
REQ-008 S1 SHALL accept a new grant when S1 is empty or S1 moves to S2 in the same cycle.
REQ-009 s_axis_tready[g] SHALL be high only for the granted requester g, and only when REQ-008 holds; all other bits SHALL be 0.
REQ-010 s_axis_tready SHALL be combinational from s_axis_tvalid, the arbitration pointer and pipeline occupancy; it SHALL NOT depend on s_axis_tdata_*.
REQ-011 Latency SHALL be 2 cycles: an input accepted at edge N SHALL present m_axis_tvalid after edge N+1, assuming no backpressure.
REQ-012 Sustained throughput SHALL be 1 product per cycle while m_axis_tready stays high.
REQ-013 While m_axis_tvalid is high and m_axis_tready is low, m_axis_tdata and m_axis_tid SHALL hold stable, S2 SHALL NOT change, and S1 SHALL keep its contents.
REQ-014 Round-robin arbitration SHALL grant the first requester with valid high, searching from pointer ptr upward modulo NREQ.
REQ-015 After each accepted input from requester g, ptr SHALL become (g+1) mod NREQ, with wrap from NREQ-1 to 0; ptr SHALL be unchanged when no transfer occurs.
REQ-016 When no s_axis_tvalid bit is high, no grant SHALL be issued and ptr SHALL hold.
REQ-017 A requester holding valid SHALL be granted within NREQ accepted transfers (no starvation).
REQ-018 Products SHALL leave in acceptance order; m_axis_tid SHALL equal the granted index registered with the operands.
REQ-019 busy SHALL equal (S1 valid OR S2 valid).

Reset
REQ-020 While rst is high at a clock edge, the block SHALL clear: S1 and S2 valid to 0, m_axis_tvalid to 0, m_axis_tdata to 0, m_axis_tid to 0, ptr to 0, busy to 0.
REQ-021 While rst is high, s_axis_tready SHALL be all zero.
REQ-022 Reset asserted mid-operation SHALL discard in-flight products without emitting them.

Configuration
REQ-023 With macro MUL_ARBITER_FIXED_PRIO_EN defined, arbitration SHALL be fixed priority: the lowest valid index wins and ptr is not implemented.
REQ-024 Without MUL_ARBITER_FIXED_PRIO_EN, round-robin per REQ-014..REQ-017 SHALL apply.
REQ-025 All other behaviour SHALL be identical in both builds.

Verification
REQ-026 Single request: rst released, req1 valid with A=4'hF, B=4'hF, m_axis_tready=1 -> s_axis_tready=4'b0010 for one cycle; 2 cycles later m_axis_tdata=8'hE1, m_axis_tid=1, busy falls 1 cycle after the output transfer.
REQ-027 All four requesters valid continuously, A=i+1, B=2, ready high -> tid sequence 0,1,2,3,0,... with products 2,4,6,8, at 1 per cycle (fixed-priority build: tid always 0).
REQ-028 Backpressure: two accepts (A=3,B=5 then A=7,B=7), then m_axis_tready low for 3 cycles -> output holds 15 stable; s_axis_tready is all zero while S1 and S2 are full; after release, 15 then 49 are output with no loss.
REQ-029 Pointer wrap: ptr=3 with requesters 3 and 0 valid -> requester 3 is granted, then requester 0.
REQ-030 Reset mid-flight: one product in S1 and one in S2, rst pulsed 1 cycle -> m_axis_tvalid=0, busy=0 and ptr=0 on the next cycle, and neither product is ever output.

Source files
------------

// File: rtl/mul_arbiter.sv
// Round-robin arbiter feeding one shared LEN x LEN multiplier through a two-stage pipeline.
// Define MUL_ARBITER_FIXED_PRIO_EN to replace round-robin with lowest-index-wins priority.
module mul_arbiter #(
    parameter int LEN  = 4,
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       s_axis_tvalid,
    output logic [NREQ-1:0]       s_axis_tready,
    input  logic [NREQ*LEN-1:0]   s_axis_tdata_a,
    input  logic [NREQ*LEN-1:0]   s_axis_tdata_b,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic [2*LEN-1:0]      m_axis_tdata,
    output logic [IDW-1:0]        m_axis_tid,
    output logic                  busy
);

    logic               s1_valid;
    logic [LEN-1:0]     s1_a;
    logic [LEN-1:0]     s1_b;
    logic [IDW-1:0]     s1_id;
    logic               s2_valid;

    logic               grant_found;
    logic [IDW-1:0]     grant_idx;
    logic [LEN-1:0]     grant_a;
    logic [LEN-1:0]     grant_b;
    logic               s2_load;
    logic               s1_free;
    logic               accept;
    logic [2*LEN-1:0]   product;

`ifndef MUL_ARBITER_FIXED_PRIO_EN
    logic [IDW-1:0]     ptr;
`endif

    assign s2_load = s1_valid && (!s2_valid || m_axis_tready);
    assign s1_free = !s1_valid || s2_load;
    assign accept  = grant_found && s1_free && !rst;
    assign product = (2*LEN)'(s1_a) * (2*LEN)'(s1_b);

    assign m_axis_tvalid = s2_valid;
    assign busy          = s1_valid | s2_valid;

`ifdef MUL_ARBITER_FIXED_PRIO_EN
    // Scan downward so the lowest valid index is the last (winning) assignment.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        grant_a     = '0;
        grant_b     = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (s_axis_tvalid[k]) begin
                grant_found = 1'b1;
                grant_idx   = IDW'(k);
                grant_a     = s_axis_tdata_a[k*LEN +: LEN];
                grant_b     = s_axis_tdata_b[k*LEN +: LEN];
            end
        end
    end
`else
    // Winner is the valid requester with the smallest distance upward from ptr.
    always_comb begin
        int best_d;
        int d;
        best_d      = NREQ;
        d           = 0;
        grant_found = 1'b0;
        grant_idx   = '0;
        grant_a     = '0;
        grant_b     = '0;
        for (int k = 0; k < NREQ; k++) begin
            d = (k + NREQ - int'(ptr)) % NREQ;
            if (s_axis_tvalid[k] && d < best_d) begin
                best_d      = d;
                grant_found = 1'b1;
                grant_idx   = IDW'(k);
                grant_a     = s_axis_tdata_a[k*LEN +: LEN];
                grant_b     = s_axis_tdata_b[k*LEN +: LEN];
            end
        end
    end
`endif

    always_comb begin
        s_axis_tready = '0;
        if (accept)
            s_axis_tready[grant_idx] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid     <= 1'b0;
            s1_a         <= '0;
            s1_b         <= '0;
            s1_id        <= '0;
            s2_valid     <= 1'b0;
            m_axis_tdata <= '0;
            m_axis_tid   <= '0;
`ifndef MUL_ARBITER_FIXED_PRIO_EN
            ptr          <= '0;
`endif
        end else begin
            if (s2_load) begin
                s2_valid     <= 1'b1;
                m_axis_tdata <= product;
                m_axis_tid   <= s1_id;
            end else if (m_axis_tready) begin
                s2_valid <= 1'b0;
            end

            if (accept) begin
                s1_valid <= 1'b1;
                s1_a     <= grant_a;
                s1_b     <= grant_b;
                s1_id    <= grant_idx;
            end else if (s2_load) begin
                s1_valid <= 1'b0;
            end

`ifndef MUL_ARBITER_FIXED_PRIO_EN
            if (accept)
                ptr <= (grant_idx == IDW'(NREQ - 1)) ? '0 : grant_idx + 1'b1;
`endif
        end
    end

endmodule

// File: tb/tb_mul_arbiter.sv
// Scoreboard bench for mul_arbiter: a queue-based reference model predicts grants and products.
module tb_mul_arbiter;

    localparam int LEN  = 4;
    localparam int NREQ = 4;
    localparam int IDW  = 2;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic [NREQ-1:0]      s_axis_tvalid = '0;
    logic [NREQ-1:0]      s_axis_tready;
    logic [NREQ*LEN-1:0]  s_axis_tdata_a = '0;
    logic [NREQ*LEN-1:0]  s_axis_tdata_b = '0;
    logic                 m_axis_tvalid;
    logic                 m_axis_tready = 1'b1;
    logic [2*LEN-1:0]     m_axis_tdata;
    logic [IDW-1:0]       m_axis_tid;
    logic                 busy;

    mul_arbiter #(.LEN(LEN), .NREQ(NREQ), .IDW(IDW)) dut (
        .clk            (clk),
        .rst            (rst),
        .s_axis_tvalid  (s_axis_tvalid),
        .s_axis_tready  (s_axis_tready),
        .s_axis_tdata_a (s_axis_tdata_a),
        .s_axis_tdata_b (s_axis_tdata_b),
        .m_axis_tvalid  (m_axis_tvalid),
        .m_axis_tready  (m_axis_tready),
        .m_axis_tdata   (m_axis_tdata),
        .m_axis_tid     (m_axis_tid),
        .busy           (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int id;
        int prod;
    } exp_t;

    exp_t q[$];
    int   mptr = 0;
    int   n_checks = 0;
    int   n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference arbitration: first valid index counting upward from the pointer.
    function automatic int pick(input logic [3:0] v, input int p);
        int j;
`ifdef MUL_ARBITER_FIXED_PRIO_EN
        for (int i = 0; i < 4; i++) begin
            j = i;
            if (v[j[1:0]]) return j;
        end
`else
        for (int k = 0; k < 4; k++) begin
            j = (p + k) % 4;
            if (v[j[1:0]]) return j;
        end
`endif
        return -1;
    endfunction

    // Input side: predict s_axis_tready and busy, then log accepted operands.
    always @(negedge clk) begin
        int g;
        logic [3:0] exp_rdy;
        int a;
        int b;
        g = pick(s_axis_tvalid, mptr);
        exp_rdy = '0;
        if (!rst && g >= 0 && (q.size() < 2 || m_axis_tready))
            exp_rdy[g[1:0]] = 1'b1;
        chk("s_tready", 32'(s_axis_tready), 32'(exp_rdy));
        chk("busy", 32'(busy), 32'(q.size() > 0));
        if (rst) begin
            q.delete();
            mptr = 0;
        end else if (exp_rdy != 0) begin
            a = int'(4'(s_axis_tdata_a >> (4 * g)));
            b = int'(4'(s_axis_tdata_b >> (4 * g)));
            q.push_back('{id: g, prod: a * b});
            mptr = (g + 1) % 4;
        end
    end

    // Output side: pop on each output transfer and check hold behaviour under backpressure.
    logic       prev_v = 1'b0;
    logic       prev_r = 1'b0;
    logic       prev_rst = 1'b1;
    logic [7:0] prev_d = '0;
    logic [1:0] prev_id = '0;

    always @(negedge clk) begin
        exp_t e;
        #1;
        if (prev_v && !prev_r && !prev_rst) begin
            chk("hold_valid", 32'(m_axis_tvalid), 32'(1));
            chk("hold_data", 32'(m_axis_tdata), 32'(prev_d));
            chk("hold_id", 32'(m_axis_tid), 32'(prev_id));
        end
        if (!rst && m_axis_tvalid && m_axis_tready) begin
            if (q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_output: actual tid=%0d data=%0h required no output", m_axis_tid, m_axis_tdata);
            end else begin
                e = q.pop_front();
                chk("tid", 32'(m_axis_tid), 32'(e.id));
                chk("tdata", 32'(m_axis_tdata), 32'(e.prod));
            end
        end
        prev_v   = m_axis_tvalid;
        prev_r   = m_axis_tready;
        prev_rst = rst;
        prev_d   = m_axis_tdata;
        prev_id  = m_axis_tid;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [3:0] a, input logic [3:0] b);
        s_axis_tdata_a[i*4 +: 4] = a;
        s_axis_tdata_b[i*4 +: 4] = b;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        int budget;

        // Reset state
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        chk("rst_tvalid", 32'(m_axis_tvalid), 32'(0));
        chk("rst_tdata", 32'(m_axis_tdata), 32'(0));
        chk("rst_tid", 32'(m_axis_tid), 32'(0));
        chk("rst_busy", 32'(busy), 32'(0));
        chk("rst_tready", 32'(s_axis_tready), 32'(0));

        // Single request from requester 1: 15*15 with two-cycle latency
        tick();
        rst = 1'b0;
        set_req(1, 4'hF, 4'hF);
        s_axis_tvalid = 4'b0010;
        @(negedge clk);
        chk("single_tready", 32'(s_axis_tready), 32'(4'b0010));
        tick();
        s_axis_tvalid = '0;
        @(negedge clk);
        chk("lat_tvalid_early", 32'(m_axis_tvalid), 32'(0));
        @(negedge clk);
        chk("lat_tvalid", 32'(m_axis_tvalid), 32'(1));
        chk("lat_tdata", 32'(m_axis_tdata), 32'(8'hE1));
        chk("lat_tid", 32'(m_axis_tid), 32'(1));
        @(negedge clk);
        chk("busy_fall", 32'(busy), 32'(0));

        // All requesters valid, A=i+1, B=2: one product per cycle
        tick();
        for (int i = 0; i < 4; i++) set_req(i, 4'(i + 1), 4'd2);
        s_axis_tvalid = 4'b1111;
        @(posedge clk);
        @(posedge clk);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("throughput", 32'(m_axis_tvalid), 32'(1));
        end
        tick();
        s_axis_tvalid = '0;
        repeat (4) tick();

        // Backpressure: 3*5 then 7*7, stall for three cycles
        set_req(0, 4'd3, 4'd5);
        s_axis_tvalid = 4'b0001;
        tick();
        set_req(2, 4'd7, 4'd7);
        s_axis_tvalid = 4'b0100;
        tick();
        set_req(3, 4'd1, 4'd9);
        s_axis_tvalid = 4'b1000;
        m_axis_tready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("bp_tready", 32'(s_axis_tready), 32'(0));
            chk("bp_tdata", 32'(m_axis_tdata), 32'(15));
            chk("bp_tvalid", 32'(m_axis_tvalid), 32'(1));
            @(posedge clk);
        end
        #1;
        m_axis_tready = 1'b1;
        tick();
        s_axis_tvalid = '0;
        repeat (4) tick();

        // Pointer wrap: move ptr to 3, then requesters 3 and 0 compete
        set_req(2, 4'd2, 4'd3);
        s_axis_tvalid = 4'b0100;
        tick();
        set_req(3, 4'd4, 4'd5);
        set_req(0, 4'd6, 4'd7);
        s_axis_tvalid = 4'b1001;
        @(negedge clk);
`ifdef MUL_ARBITER_FIXED_PRIO_EN
        chk("wrap_first", 32'(s_axis_tready), 32'(4'b0001));
`else
        chk("wrap_first", 32'(s_axis_tready), 32'(4'b1000));
`endif
        tick();
        @(negedge clk);
        chk("wrap_second", 32'(s_axis_tready), 32'(4'b0001));
        tick();
        s_axis_tvalid = '0;
        repeat (4) tick();

        // Reset mid-flight with S1 and S2 both occupied
        m_axis_tready = 1'b0;
        set_req(0, 4'd5, 4'd6);
        s_axis_tvalid = 4'b0001;
        tick();
        set_req(1, 4'd9, 4'd9);
        s_axis_tvalid = 4'b0010;
        tick();
        s_axis_tvalid = '0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        m_axis_tready = 1'b1;
        s_axis_tvalid = 4'b1111;
        @(negedge clk);
        chk("midrst_tvalid", 32'(m_axis_tvalid), 32'(0));
        chk("midrst_busy", 32'(busy), 32'(0));
        chk("midrst_ptr0", 32'(s_axis_tready), 32'(4'b0001));
        tick();
        s_axis_tvalid = '0;
        repeat (4) tick();

        // Randomized traffic with random backpressure
        for (int n = 0; n < 400; n++) begin
            s_axis_tvalid  = 4'($urandom_range(0, 15));
            s_axis_tdata_a = 16'($urandom);
            s_axis_tdata_b = 16'($urandom);
            m_axis_tready  = ($urandom_range(0, 9) < 7);
            tick();
        end

        // Drain
        s_axis_tvalid = '0;
        m_axis_tready = 1'b1;
        budget = 0;
        while (q.size() > 0 && budget < 50) begin
            tick();
            budget++;
        end
        chk("drain_empty", 32'(q.size()), 32'(0));
        @(negedge clk);
        #2;
        chk("final_busy", 32'(busy), 32'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
